rng_share_arbiter: RTL and testbench

- Sequences the on-chip LFSR random number generator (clk, rstn in; rnd[BIT-1:0] out; new word every 33 clocks after its reset releases) and shares its output between NREQ requesters.
- Drives the generator's reset and discards its warm-up words.
- Splits each fresh word into OUT_W-bit slices and hands each slice to exactly one requester, round-robin. A slice is never issued twice.
- Sits between the generator and the event-save / UFM consumers (nonce, jitter, scrub-address users).

---
 rtl/rng_share_pkg.sv | 43 ++++
 rtl/rr_arbiter.sv | 48 ++++
 rtl/rng_share_arbiter.sv | 137 +++++++++++++
 tb/tb_rng_share_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/rng_share_pkg.sv
// Shared types and width helpers for the RNG share arbiter.
package rng_share_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WARM = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam int BIT_DEF   = 512;
    localparam int OUT_W_DEF = 32;
    localparam int SLICES    = BIT_DEF / OUT_W_DEF;

    function automatic int slices_of(input int bit_w, input int out_w);
        return bit_w / out_w;
    endfunction

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    function automatic int ptr_w(input int slices);
        return clog2_min1(slices);
    endfunction

    function automatic int left_w(input int slices);
        return clog2_min1(slices + 1);
    endfunction

    function automatic int per_w(input int period);
        return clog2_min1(period);
    endfunction

    function automatic int warm_w(input int warmup);
        return clog2_min1(warmup + 1);
    endfunction

    function automatic int idx_w(input int nreq);
        return clog2_min1(nreq);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: combinational one-hot pick, registered last-grant pointer.
import rng_share_pkg::*;

module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] pick,
    output logic            any
);

    localparam int IDX_W = idx_w(NREQ);

    logic [IDX_W-1:0] last_gnt;
    logic [IDX_W-1:0] pick_idx;
    logic             found;
    int               idx;

    // Scan requesters starting one past the last winner.
    always_comb begin
        pick_idx = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_gnt) + k) % NREQ;
            if (!found && req[idx[IDX_W-1:0]]) begin
                found    = 1'b1;
                pick_idx = idx[IDX_W-1:0];
            end
        end
    end

    assign any  = found;
    assign pick = found ? (NREQ'(1) << pick_idx) : '0;

    // Pointer starts at the last requester so the first grant goes to requester 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_gnt <= IDX_W'(NREQ - 1);
        end else if (advance) begin
            last_gnt <= pick_idx;
        end
    end

endmodule

// File: rtl/rng_share_arbiter.sv
// Sequences the LFSR generator, discards warm-up words and deals out
// OUT_W-bit slices of each fresh word to requesters round-robin.
import rng_share_pkg::*;

module rng_share_arbiter #(
    parameter int BIT        = 512,
    parameter int OUT_W      = 32,
    parameter int NREQ       = 4,
    parameter int RND_PERIOD = 33,
    parameter int WARMUP     = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    output logic             gen_rstn,
    input  logic [BIT-1:0]   rnd,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [OUT_W-1:0] rdata,
    output logic             rvalid,
    output logic             ready
);

    localparam int N_SLICES = slices_of(BIT, OUT_W);
    localparam int PTR_W    = ptr_w(N_SLICES);
    localparam int LEFT_W   = left_w(N_SLICES);
    localparam int PER_W    = per_w(RND_PERIOD);
    localparam int WARM_W   = warm_w(WARMUP);

    state_t            state;
    logic              gen_rstn_reg;
    logic [PER_W-1:0]  per_cnt;
    logic              fresh;
    logic [WARM_W-1:0] warm_cnt;
    logic [BIT-1:0]    word_q;
    logic [LEFT_W-1:0] slices_left;
    logic [PTR_W-1:0]  slice_ptr;
    logic [NREQ-1:0]   gnt_reg;
    logic [OUT_W-1:0]  rdata_reg;
    logic              rvalid_reg;
    logic [NREQ-1:0]   pick;
    logic              any;
    logic              issue;

    // A grant is only issued outside fresh cycles, while slices remain and en holds.
    assign issue = (state == ST_RUN) && en && !fresh && (slices_left != '0) && any;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .clk     (clk),
        .rstn    (rstn),
        .req     (req),
        .advance (issue),
        .pick    (pick),
        .any     (any)
    );

    // Mirror the generator's update timing; fresh marks the cycle after an update.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            per_cnt <= '0;
            fresh   <= 1'b0;
        end else if (!gen_rstn_reg) begin
            per_cnt <= '0;
            fresh   <= 1'b0;
        end else begin
            fresh   <= (per_cnt == PER_W'(RND_PERIOD - 1));
            per_cnt <= (per_cnt == PER_W'(RND_PERIOD - 1)) ? '0 : per_cnt + PER_W'(1);
        end
    end

    // Sequencing FSM with registered grant outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= ST_OFF;
            gen_rstn_reg <= 1'b0;
            warm_cnt     <= '0;
            word_q       <= '0;
            slices_left  <= '0;
            slice_ptr    <= '0;
            gnt_reg      <= '0;
            rdata_reg    <= '0;
            rvalid_reg   <= 1'b0;
        end else begin
            gnt_reg    <= '0;
            rvalid_reg <= 1'b0;
            if (state != ST_OFF && !en) begin
                state        <= ST_OFF;
                gen_rstn_reg <= 1'b0;
                warm_cnt     <= '0;
                slices_left  <= '0;
            end else begin
                case (state)
                    ST_OFF: begin
                        gen_rstn_reg <= 1'b0;
                        warm_cnt     <= '0;
                        slices_left  <= '0;
                        if (en) begin
                            gen_rstn_reg <= 1'b1;
                            state        <= ST_WARM;
                        end
                    end
                    ST_WARM: begin
                        if (fresh) begin
                            warm_cnt <= warm_cnt + WARM_W'(1);
                            if (32'(warm_cnt) + 1 >= WARMUP) begin
                                state <= ST_RUN;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (fresh) begin
                            word_q      <= rnd;
                            slices_left <= LEFT_W'(N_SLICES);
                            slice_ptr   <= '0;
                        end else if (issue) begin
                            gnt_reg     <= pick;
                            rvalid_reg  <= 1'b1;
                            rdata_reg   <= word_q[int'(slice_ptr)*OUT_W +: OUT_W];
                            slices_left <= slices_left - LEFT_W'(1);
                            if (slice_ptr != PTR_W'(N_SLICES - 1)) begin
                                slice_ptr <= slice_ptr + PTR_W'(1);
                            end
                        end
                    end
                    default: state <= ST_OFF;
                endcase
            end
        end
    end

    assign gen_rstn = gen_rstn_reg;
    assign gnt      = gnt_reg;
    assign rdata    = rdata_reg;
    assign rvalid   = rvalid_reg;
    assign ready    = (state == ST_RUN) && (slices_left != '0);

endmodule

// File: tb/tb_rng_share_arbiter.sv
// Bench for rng_share_arbiter: generator model in loop, scoreboard of grants.
module tb_rng_share_arbiter;

    localparam int BIT        = 64;
    localparam int OUT_W      = 16;
    localparam int NREQ       = 4;
    localparam int RND_PERIOD = 33;
    localparam int WARMUP     = 1;
    localparam int NSL        = BIT / OUT_W;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             en = 1'b0;
    logic             gen_rstn;
    logic [BIT-1:0]   rnd = '0;
    logic [NREQ-1:0]  req = '0;
    logic [NREQ-1:0]  gnt;
    logic [OUT_W-1:0] rdata;
    logic             rvalid;
    logic             ready;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    rng_share_arbiter #(
        .BIT(BIT), .OUT_W(OUT_W), .NREQ(NREQ), .RND_PERIOD(RND_PERIOD), .WARMUP(WARMUP)
    ) dut (
        .clk(clk), .rstn(rstn), .en(en), .gen_rstn(gen_rstn), .rnd(rnd),
        .req(req), .gnt(gnt), .rdata(rdata), .rvalid(rvalid), .ready(ready)
    );

    // Generator model: new random word every RND_PERIOD clocks after its reset releases.
    int   gcnt = 0;
    logic gen_upd = 1'b0;
    always @(posedge clk) begin
        if (!gen_rstn) begin
            gcnt    <= 0;
            gen_upd <= 1'b0;
        end else if (gcnt == RND_PERIOD - 1) begin
            rnd     <= {$urandom, $urandom};
            gcnt    <= 0;
            gen_upd <= 1'b1;
        end else begin
            gcnt    <= gcnt + 1;
            gen_upd <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: modes, queue of unissued slices, round-robin by search.
    typedef struct {
        logic [NREQ-1:0]  g;
        logic [OUT_W-1:0] d;
    } exp_t;

    exp_t             sb[$];
    logic [OUT_W-1:0] m_slices[$];
    int               m_mode = 0;   // 0 off, 1 warming, 2 running
    int               m_warm = 0;
    int               m_last = NREQ - 1;
    bit               m_gen = 1'b0;
    bit               m_ready = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            if (!rstn) begin
                m_mode = 0; m_gen = 1'b0; m_warm = 0; m_last = NREQ - 1;
                m_slices.delete(); sb.delete();
            end else if (m_mode != 0 && !en) begin
                m_mode = 0; m_gen = 1'b0; m_warm = 0; m_slices.delete();
            end else if (m_mode == 0) begin
                if (en) begin m_gen = 1'b1; m_mode = 1; end
            end else if (m_mode == 1) begin
                if (gen_upd) begin
                    m_warm++;
                    if (m_warm >= WARMUP) m_mode = 2;
                end
            end else begin
                if (gen_upd) begin
                    m_slices.delete();
                    for (int s = 0; s < NSL; s++) m_slices.push_back(rnd[s*OUT_W +: OUT_W]);
                end else if (m_slices.size() > 0 && req != '0) begin
                    int p;
                    exp_t e;
                    p = 0;
                    for (int k = 1; k <= NREQ; k++) begin
                        p = (m_last + k) % NREQ;
                        if (req[p]) break;
                    end
                    e.g = NREQ'(1) << p;
                    e.d = m_slices.pop_front();
                    sb.push_back(e);
                    m_last = p;
                end
            end
            m_ready = (m_mode == 2) && (m_slices.size() > 0);
        end
    end

    // Monitor: compares DUT outputs against the scoreboard each falling edge.
    initial begin
        forever begin
            exp_t e;
            bit   ev;
            @(negedge clk);
            ev = sb.size() > 0;
            e.g = '0;
            e.d = '0;
            if (ev) e = sb.pop_front();
            chk("rvalid", 64'(rvalid), 64'(ev));
            chk("gnt", 64'(gnt), 64'(e.g));
            if (ev && rvalid) begin
                chk("rdata", 64'(rdata), 64'(e.d));
                $display("grant gnt=%b rdata=%h t=%0t", gnt, rdata, $time);
            end
            chk("ready", 64'(ready), 64'(m_ready));
            chk("gen_rstn", 64'(gen_rstn), 64'(m_gen));
        end
    end

    initial begin
        int cyc;
        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_gen_rstn", 64'(gen_rstn), 64'd0);
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_ready", 64'(ready), 64'd0);

        // Startup: first word discarded, ready one cycle after the second fresh.
        rstn = 1'b1;
        en   = 1'b1;
        cyc  = 0;
        while (!ready && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("ready_latency", 64'(cyc), 64'd68);

        // All requesting: rotate 0,1,2,3 then stall until next word.
        req = 4'b1111;
        repeat (40) @(negedge clk);

        // Single requester across ten periods.
        req = 4'b0001;
        repeat (10 * RND_PERIOD) @(negedge clk);

        // Sparse random requests; freshes land mid-word.
        for (int i = 0; i < 1200; i++) begin
            req = ($urandom_range(0, 3) == 0) ? NREQ'($urandom) : '0;
            @(negedge clk);
        end

        // Drop en right after a grant, then re-enable.
        req = 4'b1111;
        cyc = 0;
        while (!rvalid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("grant_before_en_drop", 64'(rvalid), 64'd1);
        en = 1'b0;
        repeat (60) @(negedge clk);
        en = 1'b1;
        repeat (150) @(negedge clk);

        // Asynchronous reset mid-run while requests are high.
        cyc = 0;
        while (!rvalid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("grant_before_rstn", 64'(rvalid), 64'd1);
        #2 rstn = 1'b0;
        #1;
        chk("arst_gnt", 64'(gnt), 64'd0);
        chk("arst_rvalid", 64'(rvalid), 64'd0);
        chk("arst_ready", 64'(ready), 64'd0);
        chk("arst_gen_rstn", 64'(gen_rstn), 64'd0);
        @(negedge clk);
        #2 rstn = 1'b1;
        repeat (150) @(negedge clk);

        req = '0;
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
